// File: rtl/div_pkg.sv
// Shared types and sizing constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CYCLES = DIV_WIDTH;
    localparam int unsigned DIV_CNT_W  = $clog2(DIV_CYCLES);

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_cur,
    input  logic [WIDTH-1:0] quo_cur,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The partial remainder is always below the divisor between steps, so only the
    // shifted value and the trial difference need the extra bit.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        shifted  = {rem_cur, quo_cur[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        fits     = ~diff[WIDTH];
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_cur[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider for the execute stage (quotient -> LO,
// remainder -> HI), one restoring iteration per cycle with abort on flush.
module iter_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_end
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] result_d, remainder_d;
    logic             end_d;
    logic [WIDTH-1:0] step_rem, step_quo;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_cur (rem_q),
        .quo_cur (quo_q),
        .divisor (dvs_q),
        .rem_next(step_rem),
        .quo_next(step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zero_d      = zero_q;
        result_d    = div_result;
        remainder_d = div_remainder;
        end_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (div_begin) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = magnitude(div_op1, div_sign);
                    dvs_d   = magnitude(div_op2, div_sign);
                    q_neg_d = div_sign & (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]);
                    r_neg_d = div_sign & div_op1[WIDTH-1];
                    zero_d  = (div_op2 == '0);
                end
            end
            BUSY: begin
                if (!div_begin) begin
                    // Flushed: drop the operation, leave the visible results alone.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = DONE;
                        cnt_d       = '0;
                        end_d       = 1'b1;
                        result_d    = zero_q  ? '1 : (q_neg_q ? -step_quo : step_quo);
                        // With a zero divisor R ends as |op1|, so this restores op1.
                        remainder_d = r_neg_q ? -step_rem : step_rem;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            zero_q        <= 1'b0;
            div_result    <= '0;
            div_remainder <= '0;
            div_end       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            zero_q        <= zero_d;
            div_result    <= result_d;
            div_remainder <= remainder_d;
            div_end       <= end_d;
        end
    end

endmodule
